// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared types and constants for the SPI command slave.
//   cmd_e   : command codes carried in the CMD byte of a command/data pair
//   phase_e : which byte of the pair the next complete frame belongs to
//   STAT_*  : bit positions inside the status byte returned by RD_STATUS
package spi_slave_pkg;

    typedef enum logic [7:0] {
        CMD_WR_ADDR   = 8'h01,
        CMD_WR_DATA   = 8'h02,
        CMD_RD_DATA   = 8'h03,
        CMD_SAMPLE    = 8'h04,
        CMD_RD_STATUS = 8'h05
    } cmd_e;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } phase_e;

    localparam int STAT_BUSY      = 7;
    localparam int STAT_CMD_ERR   = 6;
    localparam int STAT_FRAME_ERR = 5;
    localparam int STAT_DONE      = 4;
    localparam int STAT_CMD_MSB   = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous input, with
// single-clk rise/fall pulses derived from the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   rise, fall : one-clk pulses on synchronized 0->1 / 1->0 transitions
// RST_VAL is the level the chain assumes during reset, so that no edge is
// reported for a pin that simply sits at that level when reset releases.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI mode-0 slave decoding command/data byte pairs into
// register-file accesses, sample triggers and status reads. Everything runs
// on clk; sck/ssb/mosi are oversampled (clk must be >= 8x SCK).
//   sck, ssb, mosi, miso       : SPI pins (ssb active-low)
//   reg_addr, reg_wdata        : register address / write data
//   reg_we, reg_re             : one-clk write / read strobes
//   reg_rdata                  : read data, valid RD_LAT clks after reg_re
//   sample_req, sample_arg     : one-clk sample trigger and its argument
//   sample_busy, sample_done   : core busy level and completion pulse
// Optional: define SPI_SLAVE_AUTO_INC_EN to post-increment reg_addr after
// every WR_DATA write and every RD_DATA preload.
module spi_cmd_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  ssb,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  sample_req,
    output logic [DATA_WIDTH-1:0] sample_arg,
    input  logic                  sample_busy,
    input  logic                  sample_done
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);

    logic sck_rise, sck_fall, ssb_rise, ssb_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_p;
    logic mosi_s;

    phase_e phase_q, phase_d;
    logic in_frame_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_q, tx_q, status;
    logic [7:0] cmd_q;
    logic [3:0] last_cmd_q;
    logic cmd_err_q, frame_err_q, done_q;
    logic [RD_LAT-1:0] rd_vld_p;

    logic shift_in, byte_done, frame_bad, set_frame_err;
    logic exec, do_wr_addr, do_wr_data, do_sample, do_clr, set_cmd_err;
    logic start_rd, load_status;

    // ssb resets low so a select already held low at reset release is not
    // mistaken for a new frame start.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .din(sck), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ssb (
        .clk(clk), .reset(reset), .din(ssb), .rise(ssb_rise), .fall(ssb_fall)
    );

    // mosi shares the sck synchronizer latency, so it is aligned with sck_rise
    always_ff @(posedge clk) begin
        mosi_sync_p <= (mosi_sync_p << 1) | SYNC_STAGES'(mosi);
    end
    assign mosi_s = mosi_sync_p[SYNC_STAGES-1];

    assign shift_in      = in_frame_q && sck_rise && (bit_cnt_q != FULL);
    assign byte_done     = in_frame_q && ssb_rise && (bit_cnt_q == FULL);
    assign frame_bad     = in_frame_q && ssb_rise && (bit_cnt_q != FULL) && (bit_cnt_q != '0);
    assign set_frame_err = frame_bad || (in_frame_q && sck_rise && (bit_cnt_q == FULL));

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = sample_busy;
        status[STAT_CMD_ERR]              = cmd_err_q;
        status[STAT_FRAME_ERR]            = frame_err_q;
        status[STAT_DONE]                 = done_q;
        status[STAT_CMD_MSB:0]            = last_cmd_q;
    end

    always_ff @(posedge clk) begin
        if (reset) phase_q <= CMD;
        else       phase_q <= phase_d;
    end

    always_comb begin
        phase_d     = phase_q;
        exec        = 1'b0;
        do_wr_addr  = 1'b0;
        do_wr_data  = 1'b0;
        do_sample   = 1'b0;
        do_clr      = 1'b0;
        set_cmd_err = 1'b0;
        start_rd    = 1'b0;
        load_status = 1'b0;
        if (byte_done) begin
            if (phase_q == CMD) begin
                phase_d     = DATA;
                start_rd    = (rx_q[7:0] == CMD_RD_DATA);
                load_status = (rx_q[7:0] == CMD_RD_STATUS);
            end else begin
                phase_d = CMD;
                exec    = 1'b1;
                case (cmd_q)
                    CMD_WR_ADDR:   do_wr_addr = 1'b1;
                    CMD_WR_DATA:   do_wr_data = 1'b1;
                    CMD_RD_DATA:   ;
                    CMD_SAMPLE:    if (sample_busy) set_cmd_err = 1'b1;
                                   else             do_sample   = 1'b1;
                    CMD_RD_STATUS: do_clr = 1'b1;
                    default:       set_cmd_err = 1'b1;
                endcase
            end
        end
    end

    // rx is pure data: no reset needed, only written while a frame is open
    always_ff @(posedge clk) begin
        if (shift_in) rx_q <= {rx_q[DATA_WIDTH-2:0], mosi_s};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_frame_q  <= 1'b0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            last_cmd_q  <= '0;
            tx_q        <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            sample_req  <= 1'b0;
            sample_arg  <= '0;
            cmd_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
            rd_vld_p    <= '0;
        end else begin
            if (ssb_fall) begin
                in_frame_q <= 1'b1;
                bit_cnt_q  <= '0;
            end else if (ssb_rise) begin
                in_frame_q <= 1'b0;
            end else if (shift_in) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (byte_done && phase_q == CMD) cmd_q <= rx_q[7:0];
            if (exec) last_cmd_q <= cmd_q[3:0];

            reg_we     <= do_wr_data;
            reg_re     <= start_rd;
            sample_req <= do_sample;
            if (do_wr_data) reg_wdata  <= rx_q;
            if (do_sample)  sample_arg <= rx_q;

            // read-data valid travels alongside the reg_re pulse
            rd_vld_p[0] <= reg_re;
            for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];

            if (do_wr_addr) reg_addr <= rx_q;
`ifdef SPI_SLAVE_AUTO_INC_EN
            else if (reg_we || rd_vld_p[RD_LAT-1]) reg_addr <= reg_addr + DATA_WIDTH'(1);
`endif

            // tx: read preload beats everything; otherwise reload at byte end
            if (rd_vld_p[RD_LAT-1])        tx_q <= reg_rdata;
            else if (byte_done)            tx_q <= load_status ? status : '0;
            else if (in_frame_q && sck_fall) tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};

            // clear first so a coincident set wins
            if (do_clr) begin
                cmd_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
                done_q      <= 1'b0;
            end
            if (set_cmd_err)   cmd_err_q   <= 1'b1;
            if (set_frame_err) frame_err_q <= 1'b1;
            if (sample_done)   done_q      <= 1'b1;
        end
    end

    assign miso = tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_cmd_slave.sv
// tb_spi_cmd_slave: directed bench for spi_cmd_slave. Acts as SPI mode-0
// master (SCK = clk/16), models a register file with 2-clk read latency and
// checks strobes, addresses and bytes returned on miso.
// Honours SPI_SLAVE_AUTO_INC_EN for address expectations.
module tb_spi_cmd_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0, ssb = 1'b1, mosi = 1'b0;
    logic       miso;
    logic [7:0] reg_addr, reg_wdata, reg_rdata, sample_arg;
    logic       reg_we, reg_re, sample_req;
    logic       sample_busy = 1'b0, sample_done = 1'b0;

    int checks = 0;
    int errors = 0;

    int         we_cnt = 0, re_cnt = 0, req_cnt = 0;
    logic [7:0] we_addr_log[$];
    logic [7:0] we_data_last = 8'h00, re_addr_last = 8'h00;
    logic       rd_p1 = 1'b0;

    spi_cmd_slave dut (
        .clk(clk), .reset(reset), .sck(sck), .ssb(ssb), .mosi(mosi), .miso(miso),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .sample_req(sample_req), .sample_arg(sample_arg),
        .sample_busy(sample_busy), .sample_done(sample_done)
    );

    always #5 clk = ~clk;

    // register file: data valid exactly 2 clks after reg_re, junk otherwise
    always @(posedge clk) begin
        rd_p1     <= reg_re;
        reg_rdata <= rd_p1 ? 8'h5C : 8'hEE;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_addr_log.push_back(reg_addr);
            we_data_last = reg_wdata;
        end
        if (reg_re) begin
            re_cnt++;
            re_addr_last = reg_addr;
        end
        if (sample_req) req_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] data, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 8) ? data[7-i] : 1'b0;
            clks(8);
            rx  = {rx[6:0], miso};
            sck = 1'b1;
            clks(8);
            sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] data, input int nbits, output logic [7:0] rx);
        ssb = 1'b0;
        clks(6);
        spi_bits(data, nbits, rx);
        clks(6);
        ssb = 1'b1;
        clks(16);
    endtask

    task automatic xfer(input logic [7:0] c, input logic [7:0] d,
                        output logic [7:0] rx_c, output logic [7:0] rx_d);
        spi_frame(c, 8, rx_c);
        spi_frame(d, 8, rx_d);
    endtask

    task automatic test_reset;
        clks(4);
        reset = 1'b0;
        clks(2);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got %h want 00", reg_wdata); end
        checks++; if ({reg_we, reg_re, sample_req} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b want 000", {reg_we, reg_re, sample_req}); end
        checks++; if (sample_arg !== 8'h00) begin errors++; $display("FAIL reset_sample_arg got %h want 00", sample_arg); end
    endtask

    task automatic test_write;
        logic [7:0] rc, rd;
        int we0, re0;
        we0 = we_cnt; re0 = re_cnt;
        xfer(8'h01, 8'hAA, rc, rd);
        checks++; if (reg_addr !== 8'hAA) begin errors++; $display("FAIL wr_addr got %h want aa", reg_addr); end
        xfer(8'h02, 8'hBB, rc, rd);
        checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL wr_we_count got %0d want 1", we_cnt - we0); end
        checks++; if (we_data_last !== 8'hBB) begin errors++; $display("FAIL wr_wdata got %h want bb", we_data_last); end
        checks++; if (we_addr_log[we_addr_log.size()-1] !== 8'hAA) begin errors++; $display("FAIL wr_we_addr got %h want aa", we_addr_log[we_addr_log.size()-1]); end
        checks++; if (re_cnt - re0 !== 0) begin errors++; $display("FAIL wr_no_re got %0d want 0", re_cnt - re0); end
`ifdef SPI_SLAVE_AUTO_INC_EN
        checks++; if (reg_addr !== 8'hAB) begin errors++; $display("FAIL wr_addr_after got %h want ab", reg_addr); end
`else
        checks++; if (reg_addr !== 8'hAA) begin errors++; $display("FAIL wr_addr_after got %h want aa", reg_addr); end
`endif
    endtask

    task automatic test_read;
        logic [7:0] rc, rd;
        int we0, re0;
        xfer(8'h01, 8'h10, rc, rd);
        we0 = we_cnt; re0 = re_cnt;
        xfer(8'h03, 8'hFF, rc, rd);
        checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL rd_re_count got %0d want 1", re_cnt - re0); end
        checks++; if (re_addr_last !== 8'h10) begin errors++; $display("FAIL rd_re_addr got %h want 10", re_addr_last); end
        checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL rd_miso_data got %h want 5c", rd); end
        checks++; if (rc !== 8'h00) begin errors++; $display("FAIL rd_miso_cmd got %h want 00", rc); end
        checks++; if (we_cnt - we0 !== 0) begin errors++; $display("FAIL rd_no_we got %0d want 0", we_cnt - we0); end
`ifdef SPI_SLAVE_AUTO_INC_EN
        checks++; if (reg_addr !== 8'h11) begin errors++; $display("FAIL rd_addr_after got %h want 11", reg_addr); end
`else
        checks++; if (reg_addr !== 8'h10) begin errors++; $display("FAIL rd_addr_after got %h want 10", reg_addr); end
`endif
    endtask

    task automatic test_sample;
        logic [7:0] rc, rd;
        int q0;
        q0 = req_cnt;
        xfer(8'h04, 8'h03, rc, rd);
        checks++; if (req_cnt - q0 !== 1) begin errors++; $display("FAIL smp_req_count got %0d want 1", req_cnt - q0); end
        checks++; if (sample_arg !== 8'h03) begin errors++; $display("FAIL smp_arg got %h want 03", sample_arg); end
        sample_busy = 1'b1;
        xfer(8'h04, 8'h03, rc, rd);
        checks++; if (req_cnt - q0 !== 1) begin errors++; $display("FAIL smp_busy_drop got %0d want 1", req_cnt - q0); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'hC4) begin errors++; $display("FAIL smp_status1 got %h want c4", rd); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h85) begin errors++; $display("FAIL smp_status2 got %h want 85", rd); end
        sample_busy = 1'b0;
    endtask

    task automatic test_bad_cmd;
        logic [7:0] rc, rd;
        int we0, re0, q0;
        we0 = we_cnt; re0 = re_cnt; q0 = req_cnt;
        xfer(8'h07, 8'h12, rc, rd);
        checks++; if ((we_cnt - we0) + (re_cnt - re0) + (req_cnt - q0) !== 0) begin errors++; $display("FAIL bad_strobes got %0d want 0", (we_cnt - we0) + (re_cnt - re0) + (req_cnt - q0)); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if ((rd & 8'hF0) !== 8'h40) begin errors++; $display("FAIL bad_status got %h want 4x", rd); end
    endtask

    task automatic test_frame_err;
        logic [7:0] rc, rd;
        spi_frame(8'hA5, 5, rc);
        xfer(8'h01, 8'h33, rc, rd);
        checks++; if (reg_addr !== 8'h33) begin errors++; $display("FAIL ferr_addr got %h want 33", reg_addr); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h21) begin errors++; $display("FAIL ferr_status got %h want 21", rd); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h05) begin errors++; $display("FAIL ferr_cleared got %h want 05", rd); end
    endtask

    task automatic test_overrun;
        logic [7:0] rc, rd;
        spi_frame(8'h01, 9, rc);
        spi_frame(8'h44, 8, rd);
        checks++; if (reg_addr !== 8'h44) begin errors++; $display("FAIL ovr_addr got %h want 44", reg_addr); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h21) begin errors++; $display("FAIL ovr_status got %h want 21", rd); end
    endtask

    task automatic test_done_sticky;
        logic [7:0] rc, rd;
        sample_done = 1'b1;
        clks(1);
        sample_done = 1'b0;
        clks(2);
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h15) begin errors++; $display("FAIL done_status got %h want 15", rd); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h05) begin errors++; $display("FAIL done_cleared got %h want 05", rd); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] rc, rd;
        spi_frame(8'h01, 8, rc);
        ssb = 1'b0;
        clks(6);
        spi_bits(8'h33, 3, rd);
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        spi_bits(8'h00, 3, rd);
        clks(6);
        ssb = 1'b1;
        clks(16);
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL rstmid_addr got %h want 00", reg_addr); end
        xfer(8'h01, 8'h55, rc, rd);
        checks++; if (reg_addr !== 8'h55) begin errors++; $display("FAIL rstmid_cmd_phase got %h want 55", reg_addr); end
        xfer(8'h05, 8'h00, rc, rd);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rstmid_status got %h want 01", rd); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rc, rd;
        we_addr_log.delete();
        xfer(8'h01, 8'hFF, rc, rd);
        xfer(8'h02, 8'h11, rc, rd);
        xfer(8'h02, 8'h22, rc, rd);
        checks++; if (we_addr_log.size() !== 2) begin errors++; $display("FAIL b2b_we_count got %0d want 2", we_addr_log.size()); end
        checks++; if (we_data_last !== 8'h22) begin errors++; $display("FAIL b2b_wdata got %h want 22", we_data_last); end
        if (we_addr_log.size() == 2) begin
            checks++; if (we_addr_log[0] !== 8'hFF) begin errors++; $display("FAIL b2b_addr0 got %h want ff", we_addr_log[0]); end
`ifdef SPI_SLAVE_AUTO_INC_EN
            checks++; if (we_addr_log[1] !== 8'h00) begin errors++; $display("FAIL b2b_addr1 got %h want 00", we_addr_log[1]); end
`else
            checks++; if (we_addr_log[1] !== 8'hFF) begin errors++; $display("FAIL b2b_addr1 got %h want ff", we_addr_log[1]); end
`endif
        end
`ifdef SPI_SLAVE_AUTO_INC_EN
        checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL b2b_addr_end got %h want 01", reg_addr); end
`else
        checks++; if (reg_addr !== 8'hFF) begin errors++; $display("FAIL b2b_addr_end got %h want ff", reg_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_sample();
        test_bad_cmd();
        test_frame_err();
        test_overrun();
        test_done_sticky();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
